reg_file_be: RTL and testbench

- Parametrised multi-entry register array for the CPU datapath.
- Generalises the single 32-bit enabled, clearable register into DEPTH entries of WIDTH bits.
- Provides one write port with byte enables, two combinational read ports, optional write-to-read bypass and an optional hardwired zero entry.
- Provides a sequenced clear-all sweep, so the array can be reinitialised without asserting reset.

---
 rtl/reg_file_be.sv | 145 ++++++++++++++
 tb/tb_reg_file_be.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_be.sv
//------------------------------------------------------------------------------
// Module   : reg_file_be
// Purpose  : DEPTH x WIDTH register array with one byte-enabled write port,
//            two combinational read ports, optional write-to-read bypass,
//            optional hardwired zero entry and a sequenced clear-all sweep.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_be #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic                 We,
  input  logic [AW-1:0]        Wa,
  input  logic [WIDTH-1:0]     Wd,
  input  logic [WIDTH/8-1:0]   Be,
  input  logic [AW-1:0]        Ra1,
  input  logic [AW-1:0]        Ra2,
  output logic [WIDTH-1:0]     Rd1,
  output logic [WIDTH-1:0]     Rd2,
  input  logic                 Init,
  output logic                 Busy
);

  localparam int DEPTH     = 2 ** AW;
  localparam int NB        = WIDTH / 8;
  localparam bit ZERO_EN   = (ZERO_REG != 0);
  localparam bit BYPASS_EN = (BYPASS != 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t            state_q;
  logic [AW-1:0]     cnt_q;
  logic              busy_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              zero_wr_d;
  logic              wacc_d;
  logic [WIDTH-1:0]  wr_merge_d;
  logic [WIDTH-1:0]  rd1_d;
  logic [WIDTH-1:0]  rd2_d;

  // Writes to the hardwired zero entry are never accepted, so it stays 0.
  assign zero_wr_d = ZERO_EN && (Wa == '0);

  // A write is dropped while sweeping or when a sweep is being requested.
  assign wacc_d = We & ~busy_q & ~Init & ~zero_wr_d;

  // Byte-merged write word: enabled bytes from Wd, the rest from the entry.
  generate
    for (genvar b = 0; b < NB; b++) begin : g_byte
      assign wr_merge_d[8*b +: 8] = Be[b] ? Wd[8*b +: 8] : mem_q[Wa][8*b +: 8];
    end
  endgenerate

  // Sweep sequencer: IDLE -> SWEEP for exactly DEPTH edges, Busy registered.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Init) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          // Init is deliberately ignored here; a sweep never restarts.
          if (cnt_q == {AW{1'b1}}) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: reset clears everything, sweep clears one entry per edge.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (busy_q) begin
      mem_q[cnt_q] <= '0;
    end else if (wacc_d) begin
      mem_q[Wa] <= wr_merge_d;
    end
  end

  // Read port 1: stored value, optionally bypassed, masked by zero entry/reset.
  always_comb begin
    rd1_d = mem_q[Ra1];
    if (BYPASS_EN && wacc_d && (Ra1 == Wa)) begin
      rd1_d = wr_merge_d;
    end
    if (ZERO_EN && (Ra1 == '0)) begin
      rd1_d = '0;
    end
    if (Clr) begin
      rd1_d = '0;
    end
  end

  // Read port 2: identical selection to port 1, independent address.
  always_comb begin
    rd2_d = mem_q[Ra2];
    if (BYPASS_EN && wacc_d && (Ra2 == Wa)) begin
      rd2_d = wr_merge_d;
    end
    if (ZERO_EN && (Ra2 == '0)) begin
      rd2_d = '0;
    end
    if (Clr) begin
      rd2_d = '0;
    end
  end

  assign Rd1  = rd1_d;
  assign Rd2  = rd2_d;
  assign Busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_be.sv
//------------------------------------------------------------------------------
// Module   : tb_reg_file_be
// Purpose  : Self-checking bench for reg_file_be. Two instances share the
//            stimulus: A (zero entry + bypass) and B (plain entry 0, no bypass).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_be;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        We;
  logic [4:0]  Wa;
  logic [31:0] Wd;
  logic [3:0]  Be;
  logic [4:0]  Ra1;
  logic [4:0]  Ra2;
  logic        Init;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  reg_file_be #(.WIDTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) u_a (
    .Clk(Clk), .Clr(Clr), .We(We), .Wa(Wa), .Wd(Wd), .Be(Be),
    .Ra1(Ra1), .Ra2(Ra2), .Rd1(rd1_a), .Rd2(rd2_a), .Init(Init), .Busy(busy_a)
  );

  reg_file_be #(.WIDTH(32), .AW(5), .ZERO_REG(0), .BYPASS(0)) u_b (
    .Clk(Clk), .Clr(Clr), .We(We), .Wa(Wa), .Wd(Wd), .Be(Be),
    .Ra1(Ra1), .Ra2(Ra2), .Rd1(rd1_b), .Rd2(rd2_b), .Init(Init), .Busy(busy_b)
  );

  // ---------------- reference model ----------------
  // inst 0 models A (zero entry, bypass), inst 1 models B.
  logic [31:0] mdl [2][32];
  int          sweep_next = -1;   // next entry to clear, -1 when not sweeping

  function automatic bit acc(int inst);
    return We && (sweep_next < 0) && !Init && !((inst == 0) && (Wa == 5'd0));
  endfunction

  function automatic logic [31:0] merged(int inst);
    logic [31:0] m;
    for (int b = 0; b < 4; b++)
      m[8*b +: 8] = Be[b] ? Wd[8*b +: 8] : mdl[inst][Wa][8*b +: 8];
    return m;
  endfunction

  function automatic logic [31:0] exp_rd(int inst, logic [4:0] a);
    if (Clr) return 32'h0;
    if ((inst == 0) && (a == 5'd0)) return 32'h0;
    if ((inst == 0) && acc(0) && (a == Wa)) return merged(0);
    return mdl[inst][a];
  endfunction

  always @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int k = 0; k < 2; k++)
        for (int e = 0; e < 32; e++) mdl[k][e] = 32'h0;
      sweep_next = -1;
    end else begin
      bit          acc0, acc1;
      logic [31:0] m0, m1;
      acc0 = acc(0); acc1 = acc(1);
      m0 = merged(0); m1 = merged(1);
      if (acc0) mdl[0][Wa] = m0;
      if (acc1) mdl[1][Wa] = m1;
      if (sweep_next >= 0) begin
        mdl[0][sweep_next] = 32'h0;
        mdl[1][sweep_next] = 32'h0;
        sweep_next = (sweep_next == 31) ? -1 : sweep_next + 1;
      end else if (Init) begin
        sweep_next = 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle, compare both instances against the model.
  always @(negedge Clk) begin
    chk("rd1_a", rd1_a, exp_rd(0, Ra1));
    chk("rd2_a", rd2_a, exp_rd(0, Ra2));
    chk("rd1_b", rd1_b, exp_rd(1, Ra1));
    chk("rd2_b", rd2_b, exp_rd(1, Ra2));
    chk("busy_a", {31'b0, busy_a}, {31'b0, (sweep_next >= 0)});
    chk("busy_b", {31'b0, busy_b}, {31'b0, (sweep_next >= 0)});
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  int nba, nbb;

  // ---------------- directed stimulus ----------------
  initial begin
    Clr = 1'b1; We = 1'b1; Wa = 5'd3; Wd = 32'hFFFF_FFFF; Be = 4'hF;
    Ra1 = 5'd3; Ra2 = 5'd0; Init = 1'b0;

    // Reads are zero while reset is held, even with a write pending.
    tick();
    @(negedge Clk);
    chk("lit_clr_rd1_a", rd1_a, 32'h0);
    chk("lit_clr_rd1_b", rd1_b, 32'h0);
    tick();
    Clr = 1'b0; We = 1'b0;

    for (int i = 0; i < 32; i++) begin
      Ra1 = 5'(i); Ra2 = 5'(31 - i);
      @(negedge Clk);
      tick();
    end
    chk("lit_busy_idle", {31'b0, busy_a}, 32'h0);

    // Full write, bypass visible on A only; same address on both ports.
    We = 1'b1; Wa = 5'd3; Wd = 32'hDEAD_BEEF; Be = 4'hF; Ra1 = 5'd3; Ra2 = 5'd3;
    @(negedge Clk);
    chk("lit_byp_full_a", rd1_a, 32'hDEAD_BEEF);
    chk("lit_byp_full_a2", rd2_a, 32'hDEAD_BEEF);
    chk("lit_nobyp_full_b", rd1_b, 32'h0);
    tick();
    We = 1'b0;
    @(negedge Clk);
    chk("lit_stored_a", rd1_a, 32'hDEAD_BEEF);
    chk("lit_stored_b", rd1_b, 32'hDEAD_BEEF);
    tick();

    // Partial byte write onto 0x11223344.
    We = 1'b1; Wa = 5'd5; Wd = 32'h1122_3344; Be = 4'hF;
    tick();
    Wd = 32'hAABB_CCDD; Be = 4'b0101; Ra1 = 5'd5;
    @(negedge Clk);
    chk("lit_byp_part_a", rd1_a, 32'h11BB_33DD);
    chk("lit_nobyp_part_b", rd1_b, 32'h1122_3344);
    tick();
    We = 1'b0;
    @(negedge Clk);
    chk("lit_part_a", rd1_a, 32'h11BB_33DD);
    chk("lit_part_b", rd1_b, 32'h11BB_33DD);
    tick();

    // Entry 0: hardwired zero on A, ordinary on B.
    We = 1'b1; Wa = 5'd0; Wd = 32'hFFFF_FFFF; Be = 4'hF; Ra1 = 5'd0;
    @(negedge Clk);
    chk("lit_zero_wcyc_a", rd1_a, 32'h0);
    tick();
    We = 1'b0;
    @(negedge Clk);
    chk("lit_zero_a", rd1_a, 32'h0);
    chk("lit_entry0_b", rd1_b, 32'hFFFF_FFFF);
    tick();

    // Be=0 write is a no-op.
    We = 1'b1; Wa = 5'd3; Wd = 32'h0; Be = 4'h0; Ra1 = 5'd3;
    @(negedge Clk);
    chk("lit_be0_byp_a", rd1_a, 32'hDEAD_BEEF);
    tick();
    We = 1'b0;
    @(negedge Clk);
    chk("lit_be0_b", rd1_b, 32'hDEAD_BEEF);
    tick();

    // Fill every entry with a nonzero pattern.
    for (int i = 0; i < 32; i++) begin
      We = 1'b1; Wa = 5'(i); Wd = 32'h0101_0101 * (i + 1); Be = 4'hF;
      Ra1 = 5'(i); Ra2 = 5'((i + 1) % 32);
      tick();
    end
    We = 1'b0;

    // One-cycle Init pulse, then observe the sweep.
    Init = 1'b1;
    tick();
    Init = 1'b0;
    nba = 0; nbb = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge Clk);
      if (busy_a) nba++;
      if (busy_b) nbb++;
      if (j == 10) begin
        chk("lit_swept9_a", rd1_a, 32'h0);
        chk("lit_unswept10_a", rd2_a, 32'h0B0B_0B0B);
        chk("lit_unswept10_b", rd2_b, 32'h0B0B_0B0B);
      end
      if (j == 32) chk("lit_drop31_a", rd1_a, 32'h0);
      if (j == 33) begin
        chk("lit_post_wr_a", rd1_a, 32'hCAFE_F00D);
        chk("lit_post_wr_b", rd1_b, 32'hCAFE_F00D);
      end
      tick();
      case (j)
        3:  Init = 1'b1;
        9:  begin Init = 1'b0; Ra1 = 5'd9; Ra2 = 5'd10; end
        12: begin We = 1'b1; Wa = 5'd31; Wd = 32'h1234_5678; Be = 4'hF; end
        13: We = 1'b0;
        31: begin We = 1'b1; Wa = 5'd7; Wd = 32'hCAFE_F00D; Be = 4'hF; Ra1 = 5'd31; end
        32: begin We = 1'b0; Ra1 = 5'd7; end
        default: ;
      endcase
    end
    chk("lit_sweep_len_a", nba, 32);
    chk("lit_sweep_len_b", nbb, 32);

    // Init and write in the same idle cycle: the write is dropped.
    We = 1'b1; Wa = 5'd4; Wd = 32'h4444_4444; Be = 4'hF;
    tick();
    Init = 1'b1; Wd = 32'h5555_5555; Ra1 = 5'd4;
    tick();
    Init = 1'b0; We = 1'b0;
    @(negedge Clk);
    chk("lit_init_busy_a", {31'b0, busy_a}, 32'h1);
    chk("lit_init_drop_a", rd1_a, 32'h4444_4444);
    chk("lit_init_drop_b", rd1_b, 32'h4444_4444);

    // Reset in the middle of the sweep aborts it.
    repeat (10) tick();
    Clr = 1'b1; Ra1 = 5'd7;
    @(negedge Clk);
    chk("lit_abort_busy_a", {31'b0, busy_a}, 32'h0);
    chk("lit_abort_rd_b", rd1_b, 32'h0);
    tick();
    Clr = 1'b0;
    @(negedge Clk);
    chk("lit_abort_cleared_b", rd1_b, 32'h0);
    tick();

    // A fresh sweep after the abort runs the full length.
    Init = 1'b1;
    tick();
    Init = 1'b0;
    nba = 0;
    for (int j = 0; j < 40; j++) begin
      Ra1 = 5'(j % 32); Ra2 = 5'((j + 16) % 32);
      @(negedge Clk);
      if (busy_a) nba++;
      tick();
    end
    chk("lit_resweep_len_a", nba, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
